// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop RxD sync, oversampled mid-bit sampling, byte held with rdrf/fe/oe flags.
// Latency ~9.5 bit periods + 2-3 cycles from start edge to rdrf; no backpressure, an unread byte causes overrun.
module uart_receiver #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       Clk_100M,
    input  logic       clr,
    input  logic       RxD,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       rdrf,
    output logic       fe,
    output logic       oe
);
    localparam int DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TCNT_W = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [TCNT_W-1:0] TICK_LAST = TCNT_W'(OVERSAMPLE - 1);
    localparam logic [TCNT_W-1:0] TICK_HALF = TCNT_W'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t            state_q;
    logic [1:0]        sync_q;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_d;
    logic [TCNT_W-1:0] tcnt_q;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q;
    logic [7:0]        rx_data_q;
    logic              rdrf_q;
    logic              fe_q;
    logic              oe_q;
    logic              rxs;
    logic              tick;
    logic              sample;

    assign rxs = sync_q[1];

    // START samples half a bit in; DATA and STOP sample a full bit after the previous sample.
    always_comb begin
        tick   = (div_q == DIV_LAST);
        div_d  = tick ? '0 : div_q + DIV_W'(1);
        sample = tick && (tcnt_q == ((state_q == S_START) ? TICK_HALF : TICK_LAST));
    end

    always_ff @(posedge Clk_100M or negedge clr) begin
        if (!clr) begin
            sync_q    <= 2'b11;
            div_q     <= '0;
            state_q   <= S_IDLE;
            tcnt_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            rdrf_q    <= 1'b0;
            fe_q      <= 1'b0;
            oe_q      <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], RxD};
            div_q  <= div_d;

            if (rd_ack && rdrf_q) begin
                rdrf_q <= 1'b0;
                fe_q   <= 1'b0;
                oe_q   <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    tcnt_q <= '0;
                    if (!rxs) state_q <= S_START;
                end
                S_START: begin
                    if (sample) begin
                        tcnt_q  <= '0;
                        bit_q   <= '0;
                        state_q <= rxs ? S_IDLE : S_DATA;
                    end else if (tick) begin
                        tcnt_q <= tcnt_q + TCNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (sample) begin
                        tcnt_q  <= '0;
                        shift_q <= {rxs, shift_q[7:1]};
                        if (bit_q == 3'd7) state_q <= S_STOP;
                        else               bit_q   <= bit_q + 3'd1;
                    end else if (tick) begin
                        tcnt_q <= tcnt_q + TCNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (sample) begin
                        tcnt_q <= '0;
                        // An ack landing on the completion cycle frees the register for this byte.
                        if (!rdrf_q || rd_ack) begin
                            rx_data_q <= shift_q;
                            rdrf_q    <= 1'b1;
                            fe_q      <= ~rxs;
                            oe_q      <= 1'b0;
                        end else begin
                            oe_q <= 1'b1;
                        end
                        state_q <= rxs ? S_IDLE : S_BREAK;
                    end else if (tick) begin
                        tcnt_q <= tcnt_q + TCNT_W'(1);
                    end
                end
                S_BREAK: begin
                    tcnt_q <= '0;
                    if (rxs) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rx_data = rx_data_q;
    assign rdrf    = rdrf_q;
    assign fe      = fe_q;
    assign oe      = oe_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 115200 baud on a 100 MHz clock (54 cycles/tick, 864 cycles/bit).
`timescale 1ns/1ps
module tb_uart_receiver;
    localparam int BIT      = 864;
    localparam int DIV      = 54;
    localparam int STOP_LEN = 648;
    localparam int FRAME    = 9 * BIT + STOP_LEN;
    localparam int LAT_MIN  = 9 * BIT + BIT / 2 - DIV;
    localparam int LAT_MAX  = 9 * BIT + BIT / 2 + 4;

    logic       clk = 1'b0;
    logic       clr;
    logic       RxD;
    logic       rd_ack;
    logic [7:0] rx_data;
    logic       rdrf;
    logic       fe;
    logic       oe;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int at_cyc;
    bit seen;

    uart_receiver #(.CLK_FREQ(100_000_000), .BAUD(115200), .OVERSAMPLE(16)) dut (
        .Clk_100M(clk), .clr(clr), .RxD(RxD), .rd_ack(rd_ack),
        .rx_data(rx_data), .rdrf(rdrf), .fe(fe), .oe(oe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic send_frame(input logic [7:0] d, input logic stop);
        RxD = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RxD = d[i];
            repeat (BIT) @(negedge clk);
        end
        RxD = stop;
        repeat (STOP_LEN) @(negedge clk);
    endtask

    task automatic wait_rdrf(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rdrf === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic pulse_ack();
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b0; RxD = 1'b1; rd_ack = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", rx_data); end
        n_checks++; if (rdrf !== 1'b0) begin n_fail++; $display("FAIL rst_rdrf: got %b want 0", rdrf); end
        n_checks++; if (fe !== 1'b0) begin n_fail++; $display("FAIL rst_fe: got %b want 0", fe); end
        n_checks++; if (oe !== 1'b0) begin n_fail++; $display("FAIL rst_oe: got %b want 0", oe); end
        clr = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++; if (rdrf !== 1'b0) begin n_fail++; $display("FAIL rst_idle_rdrf: got %b want 0", rdrf); end
    endtask

    task automatic test_basic_frame();
        int s;
        s = cyc;
        fork
            send_frame(8'hA5, 1'b1);
            wait_rdrf(FRAME, at_cyc);
        join
        n_checks++;
        if (at_cyc < 0 || (at_cyc - s) < LAT_MIN || (at_cyc - s) > LAT_MAX) begin
            n_fail++; $display("FAIL t1_latency: got %0d cycles want %0d..%0d", at_cyc - s, LAT_MIN, LAT_MAX);
        end
        n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL t1_data: got %h want a5", rx_data); end
        n_checks++; if (rdrf !== 1'b1) begin n_fail++; $display("FAIL t1_rdrf: got %b want 1", rdrf); end
        n_checks++; if (fe !== 1'b0) begin n_fail++; $display("FAIL t1_fe: got %b want 0", fe); end
        n_checks++; if (oe !== 1'b0) begin n_fail++; $display("FAIL t1_oe: got %b want 0", oe); end
        pulse_ack();
        n_checks++; if (rdrf !== 1'b0) begin n_fail++; $display("FAIL t1_ack_rdrf: got %b want 0", rdrf); end
        n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL t1_ack_data: got %h want a5", rx_data); end
    endtask

    task automatic test_glitch();
        RxD = 1'b0;
        repeat (200) @(negedge clk);
        RxD = 1'b1;
        seen = 1'b0;
        fork
            begin
                repeat (11 * BIT) @(negedge clk);
                send_frame(8'h3C, 1'b1);
            end
            for (int i = 0; i < 20 * BIT; i++) begin
                @(negedge clk);
                if (rdrf !== 1'b0 || fe !== 1'b0) seen = 1'b1;
            end
        join
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL t2_quiet: flag seen=%b want 0", seen); end
        n_checks++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL t2_data: got %h want 3c", rx_data); end
        n_checks++; if (rdrf !== 1'b1) begin n_fail++; $display("FAIL t2_rdrf: got %b want 1", rdrf); end
        n_checks++; if (fe !== 1'b0) begin n_fail++; $display("FAIL t2_fe: got %b want 0", fe); end
        pulse_ack();
    endtask

    task automatic test_framing_break();
        send_frame(8'h3C, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        RxD = 1'b1;
        @(negedge clk);
        n_checks++; if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL t3_data: got %h want 3c", rx_data); end
        n_checks++; if (rdrf !== 1'b1) begin n_fail++; $display("FAIL t3_rdrf: got %b want 1", rdrf); end
        n_checks++; if (fe !== 1'b1) begin n_fail++; $display("FAIL t3_fe: got %b want 1", fe); end
        n_checks++; if (oe !== 1'b0) begin n_fail++; $display("FAIL t3_oe: got %b want 0", oe); end
        pulse_ack();
        n_checks++; if (fe !== 1'b0) begin n_fail++; $display("FAIL t3_ack_fe: got %b want 0", fe); end
        repeat (10) @(negedge clk);
        send_frame(8'h81, 1'b1);
        n_checks++; if (rx_data !== 8'h81) begin n_fail++; $display("FAIL t3_next_data: got %h want 81", rx_data); end
        n_checks++; if (rdrf !== 1'b1) begin n_fail++; $display("FAIL t3_next_rdrf: got %b want 1", rdrf); end
        n_checks++; if (fe !== 1'b0 || oe !== 1'b0) begin n_fail++; $display("FAIL t3_next_err: got fe=%b oe=%b want 0 0", fe, oe); end
    endtask

    task automatic test_overrun();
        pulse_ack();
        n_checks++; if (rdrf !== 1'b0) begin n_fail++; $display("FAIL t4_pre_rdrf: got %b want 0", rdrf); end
        send_frame(8'h11, 1'b1);
        n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL t4_first_data: got %h want 11", rx_data); end
        send_frame(8'h22, 1'b1);
        n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL t4_data: got %h want 11", rx_data); end
        n_checks++; if (rdrf !== 1'b1) begin n_fail++; $display("FAIL t4_rdrf: got %b want 1", rdrf); end
        n_checks++; if (oe !== 1'b1) begin n_fail++; $display("FAIL t4_oe: got %b want 1", oe); end
        n_checks++; if (fe !== 1'b0) begin n_fail++; $display("FAIL t4_fe: got %b want 0", fe); end
        pulse_ack();
        n_checks++; if (rdrf !== 1'b0 || oe !== 1'b0) begin n_fail++; $display("FAIL t4_ack: got rdrf=%b oe=%b want 0 0", rdrf, oe); end
        n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL t4_ack_data: got %h want 11", rx_data); end
    endtask

    task automatic test_reset_midframe();
        RxD = 1'b0;
        repeat (BIT) @(negedge clk);
        RxD = 1'b1;
        repeat (BIT) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL t5_rst_data: got %h want 00", rx_data); end
        n_checks++; if (rdrf !== 1'b0 || fe !== 1'b0 || oe !== 1'b0) begin n_fail++; $display("FAIL t5_rst_flags: got %b%b%b want 000", rdrf, fe, oe); end
        repeat (20) @(negedge clk);
        clr = 1'b1;
        seen = 1'b0;
        fork
            send_frame(8'h5A, 1'b1);
            for (int i = 0; i < 9 * BIT; i++) begin
                @(negedge clk);
                if (rdrf !== 1'b0 || fe !== 1'b0 || oe !== 1'b0) seen = 1'b1;
            end
        join
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL t5_release: flag seen=%b want 0", seen); end
        n_checks++; if (rx_data !== 8'h5A) begin n_fail++; $display("FAIL t5_data: got %h want 5a", rx_data); end
        n_checks++; if (rdrf !== 1'b1) begin n_fail++; $display("FAIL t5_rdrf: got %b want 1", rdrf); end
    endtask

    task automatic test_ack_on_completion();
        int s_a, s_b, delay, target;
        pulse_ack();
        s_a = cyc;
        fork
            send_frame(8'h11, 1'b1);
            wait_rdrf(FRAME, at_cyc);
        join
        n_checks++; if (at_cyc < 0) begin n_fail++; $display("FAIL t6_first_timeout: rdrf never rose within %0d cycles", FRAME); end
        n_checks++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL t6_first_data: got %h want 11", rx_data); end
        // Frames are a whole number of ticks long, so frame B completes at the same offset as frame A.
        delay  = (at_cyc >= 0) ? at_cyc - s_a : 9 * BIT + BIT / 2;
        s_b    = cyc;
        target = s_b + delay;
        fork
            send_frame(8'h22, 1'b1);
            begin
                while (cyc < target - 1) @(negedge clk);
                pulse_ack();
            end
        join
        n_checks++; if (rx_data !== 8'h22) begin n_fail++; $display("FAIL t6_data: got %h want 22", rx_data); end
        n_checks++; if (rdrf !== 1'b1) begin n_fail++; $display("FAIL t6_rdrf: got %b want 1", rdrf); end
        n_checks++; if (oe !== 1'b0) begin n_fail++; $display("FAIL t6_oe: got %b want 0", oe); end
        n_checks++; if (fe !== 1'b0) begin n_fail++; $display("FAIL t6_fe: got %b want 0", fe); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_glitch();
        test_framing_break();
        test_overrun();
        test_reset_midframe();
        test_ack_on_completion();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded 200000 cycles");
        $fatal(1, "watchdog expired");
    end
endmodule
